// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   N-phase traffic-light sequencer. Each approach runs green -> yellow ->
//   optional all-red clearance, then hands over to the next approach.
//   Green length is per phase. An advance request (N) ends the green early
//   once the minimum green time has elapsed.
//
// Parameters
//   PHASES : number of approaches (>= 2)
//   CW     : counter width, must hold the largest duration
//   GREEN  : packed PHASES x CW green durations, phase p at [p*CW +: CW]
//   YELLOW : yellow duration in cycles (>= 1)
//   ALLRED : all-red clearance in cycles, 0 removes the all-red state
//   MIN_G  : minimum green before N is honoured (>= 1)
//   PW     : width of the phase index
//
// Ports
//   clk   : 1 Hz tick clock
//   rst   : synchronous active-high reset
//   N     : advance request
//   grn   : one-hot green lamps, bit p = approach p
//   yel   : one-hot yellow lamps
//   phase : index of the active approach
//   start : one-cycle pulse on the first cycle of every green not loaded by reset
module traffic_phase_ctrl #(
  parameter int                   PHASES = 3,
  parameter int                   CW     = 12,
  parameter logic [PHASES*CW-1:0] GREEN  = {CW'(13), CW'(4), CW'(10)},
  parameter int                   YELLOW = 3,
  parameter int                   ALLRED = 1,
  parameter int                   MIN_G  = 2,
  parameter int                   PW     = $clog2(PHASES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              N,
  output logic [PHASES-1:0] grn,
  output logic [PHASES-1:0] yel,
  output logic [PW-1:0]     phase,
  output logic              start
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  localparam logic [CW-1:0] MIN_M1 = CW'(MIN_G - 1);
  localparam logic [CW-1:0] YEL_M1 = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_M1  = (ALLRED > 0) ? CW'(ALLRED - 1) : '0;
  localparam logic [PW-1:0] LAST   = PW'(PHASES - 1);
  localparam bit            HAS_AR = (ALLRED > 0);

  state_t          state, state_n;
  logic [PW-1:0]   phase_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            pend, pend_n;

  logic [PHASES-1:0] grn_n, yel_n;
  logic              start_n;

  // Terminal count (duration - 1) of every phase's green, indexed by phase.
  logic [CW-1:0] green_m1 [PHASES];
  logic [CW-1:0] g_m1;
  logic [PW-1:0] next_ph;

  for (genvar p = 0; p < PHASES; p++) begin : g_green_tab
    assign green_m1[p] = GREEN[p*CW +: CW] - CW'(1);
  end

  assign g_m1    = green_m1[phase];
  assign next_ph = (phase == LAST) ? '0 : phase + PW'(1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_GREEN;
      phase <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt + CW'(1);
    pend_n  = pend;
    unique case (state)
      S_GREEN: begin
        // pend can only be set below MIN_M1, so "pend and cnt >= MIN_M1"
        // fires exactly at cnt == MIN_M1.
        if ((cnt == g_m1) || ((cnt >= MIN_M1) && (N || pend))) begin
          state_n = S_YELLOW;
          cnt_n   = '0;
          pend_n  = 1'b0;
        end else if (N) begin
          pend_n = 1'b1;
        end
      end
      S_YELLOW: begin
        if (cnt == YEL_M1) begin
          cnt_n = '0;
          if (HAS_AR) begin
            state_n = S_ALLRED;
          end else begin
            state_n = S_GREEN;
            phase_n = next_ph;
          end
        end
      end
      S_ALLRED: begin
        if (cnt == AR_M1) begin
          state_n = S_GREEN;
          phase_n = next_ph;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_GREEN;
        phase_n = '0;
        cnt_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: built from the next state so the lamps are registered and
  // line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    grn_n   = '0;
    yel_n   = '0;
    start_n = (state_n == S_GREEN) && (state != S_GREEN);
    case (state_n)
      S_GREEN:  grn_n[phase_n] = 1'b1;
      S_YELLOW: yel_n[phase_n] = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grn   <= PHASES'(1);
      yel   <= '0;
      start <= 1'b0;
    end else begin
      grn   <= grn_n;
      yel   <= yel_n;
      start <= start_n;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, n;
  logic [2:0] grn, yel;
  logic [1:0] phase;
  logic       start;

  logic       rst2, n2;
  logic [3:0] grn2, yel2;
  logic [1:0] phase2;
  logic       start2;

  int vectors     = 0;
  int miscompares = 0;

  traffic_phase_ctrl dut (
    .clk(clk), .rst(rst), .N(n),
    .grn(grn), .yel(yel), .phase(phase), .start(start)
  );

  traffic_phase_ctrl #(
    .PHASES(4),
    .CW(12),
    .GREEN({12'd5, 12'd5, 12'd5, 12'd5}),
    .YELLOW(3),
    .ALLRED(0),
    .MIN_G(2)
  ) dut4 (
    .clk(clk), .rst(rst2), .N(n2),
    .grn(grn2), .yel(yel2), .phase(phase2), .start(start2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] g, input logic [2:0] y,
                     input logic [1:0] p, input logic s);
    check({tag, ".grn"},   32'(grn),   32'(g));
    check({tag, ".yel"},   32'(yel),   32'(y));
    check({tag, ".phase"}, 32'(phase), 32'(p));
    check({tag, ".start"}, 32'(start), 32'(s));
  endtask

  // Default free-run pattern, k = cycles since reset release: {start,phase,yel,grn}
  function automatic logic [8:0] exp_free(input int k);
    int m, off, gl, r;
    logic [2:0] g, y;
    logic [1:0] p;
    logic s;
    m = k % 39;
    g = '0;
    y = '0;
    if (m < 14) begin p = 2'd0; off = 0;  gl = 10; end
    else if (m < 22) begin p = 2'd1; off = 14; gl = 4; end
    else begin p = 2'd2; off = 22; gl = 13; end
    r = m - off;
    if (r < gl) g[p] = 1'b1;
    else if (r < gl + 3) y[p] = 1'b1;
    s = (r == 0) && (k != 0);
    return {s, p, y, g};
  endfunction

  // 4-phase, 5 green + 3 yellow, no all-red: {start,phase,yel,grn}
  function automatic logic [10:0] exp_sweep(input int k);
    int m, r;
    logic [3:0] g, y;
    logic [1:0] p;
    m = k % 32;
    p = 2'(m / 8);
    r = m % 8;
    g = '0;
    y = '0;
    if (r < 5) g[p] = 1'b1;
    else y[p] = 1'b1;
    return {(r == 0) && (k != 0), p, y, g};
  endfunction

  initial begin
    logic [8:0]  e1;
    logic [10:0] e4;

    rst = 1'b1; rst2 = 1'b1; n = 1'b0; n2 = 1'b0;
    tick();
    chk("rst_a", 3'b001, 3'b000, 2'd0, 1'b0);
    tick();
    chk("rst_b", 3'b001, 3'b000, 2'd0, 1'b0);
    check("rst4.grn", 32'(grn2), 32'h1);
    check("rst4.yel", 32'(yel2), 32'h0);
    rst = 1'b0; rst2 = 1'b0;

    // Two default rotations, plus the 4-phase sweep alongside
    for (int k = 0; k < 78; k++) begin
      e1 = exp_free(k);
      chk($sformatf("free%0d", k), e1[2:0], e1[5:3], e1[7:6], e1[8]);
      check($sformatf("free%0d.onehot", k), 32'($countones(grn | yel) <= 1), 32'h1);
      e4 = exp_sweep(k);
      check($sformatf("sw%0d.grn", k),   32'(grn2),   32'(e4[3:0]));
      check($sformatf("sw%0d.yel", k),   32'(yel2),   32'(e4[7:4]));
      check($sformatf("sw%0d.phase", k), 32'(phase2), 32'(e4[9:8]));
      check($sformatf("sw%0d.start", k), 32'(start2), 32'(e4[10]));
      check($sformatf("sw%0d.onehot", k), 32'($countones(grn2 | yel2) <= 1), 32'h1);
      tick();
    end
    rst2 = 1'b1;

    // Early advance at cnt=5 of phase0
    chk("rot3", 3'b001, 3'b000, 2'd0, 1'b1);
    repeat (5) tick();
    chk("adv_pre", 3'b001, 3'b000, 2'd0, 1'b0);
    n = 1'b1;
    tick();
    n = 1'b0;
    chk("adv_y1", 3'b000, 3'b001, 2'd0, 1'b0);
    tick(); chk("adv_y2", 3'b000, 3'b001, 2'd0, 1'b0);
    tick(); chk("adv_y3", 3'b000, 3'b001, 2'd0, 1'b0);
    tick(); chk("adv_ar", 3'b000, 3'b000, 2'd0, 1'b0);
    tick(); chk("adv_g1", 3'b010, 3'b000, 2'd1, 1'b1);

    // Pending request at cnt=0 of phase1
    n = 1'b1;
    tick();
    n = 1'b0;
    chk("pend_g", 3'b010, 3'b000, 2'd1, 1'b0);
    tick(); chk("pend_y1", 3'b000, 3'b010, 2'd1, 1'b0);
    tick();
    tick(); chk("pend_y3", 3'b000, 3'b010, 2'd1, 1'b0);
    tick(); chk("pend_ar", 3'b000, 3'b000, 2'd1, 1'b0);
    tick(); chk("pend_g2", 3'b100, 3'b000, 2'd2, 1'b1);

    // Reset during yellow cycle 2 of phase2
    repeat (12) tick();
    chk("g2_last", 3'b100, 3'b000, 2'd2, 1'b0);
    tick(); chk("g2_y1", 3'b000, 3'b100, 2'd2, 1'b0);
    tick(); chk("g2_y2", 3'b000, 3'b100, 2'd2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", 3'b001, 3'b000, 2'd0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("postrst_g%0d", i), 3'b001, 3'b000, 2'd0, 1'b0);
    end
    tick(); chk("postrst_y1", 3'b000, 3'b001, 2'd0, 1'b0);

    // N held through yellow and all-red of phase0
    n = 1'b1;
    tick(); chk("ign_y2", 3'b000, 3'b001, 2'd0, 1'b0);
    tick(); chk("ign_y3", 3'b000, 3'b001, 2'd0, 1'b0);
    tick(); chk("ign_ar", 3'b000, 3'b000, 2'd0, 1'b0);
    tick(); chk("ign_g0", 3'b010, 3'b000, 2'd1, 1'b1);
    tick(); chk("ign_g1", 3'b010, 3'b000, 2'd1, 1'b0);
    tick(); chk("ign_y", 3'b000, 3'b010, 2'd1, 1'b0);

    // N pulsed only in yellow must not shorten the following green
    tick(); chk("nolatch_y2", 3'b000, 3'b010, 2'd1, 1'b0);
    n = 1'b0;
    tick(); chk("nolatch_y3", 3'b000, 3'b010, 2'd1, 1'b0);
    tick(); chk("nolatch_ar", 3'b000, 3'b000, 2'd1, 1'b0);
    tick(); chk("nolatch_g0", 3'b100, 3'b000, 2'd2, 1'b1);
    for (int i = 1; i < 13; i++) begin
      tick();
      chk($sformatf("nolatch_g%0d", i), 3'b100, 3'b000, 2'd2, 1'b0);
    end
    tick(); chk("nolatch_y", 3'b000, 3'b100, 2'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-phase traffic-light sequencer for the red_green_light design. It is the successor of the fixed three-direction controller. It cycles a configurable number of approaches through green, yellow and an optional all-red clearance, each phase with its own green duration. An early-advance request ends the current green once a minimum green time has elapsed. It sits directly behind the 1 Hz tick clock and drives the lamp decoders.

## Interface
- PHASES, 3: number of approaches; must be at least 2.
- CW, 12: counter width in bits; must hold the largest duration.
- GREEN, {13,4,10}: packed PHASES×CW vector of per-phase green cycles.
  - Phase p occupies bits [p*CW +: CW].
  - The default gives phase0=10, phase1=4, phase2=13.
  - Every entry must be at least MIN_G.
- YELLOW, 3: yellow cycles per phase; must be at least 1.
- ALLRED, 1: all-red clearance cycles after each yellow; 0 removes the all-red state.
- MIN_G, 2: minimum green cycles before an advance request is honoured; must be at least 1.
- PW, $clog2(PHASES): width of the phase index.
- clk  in  1  clock (1 cycle = 1 s in the system).
- rst  in  1  synchronous, active-high reset.
- N  in  1  advance request: end the current green early.
- grn  out  PHASES  one-hot green lamp; bit p belongs to approach p.
- yel  out  PHASES  one-hot yellow lamp.
- phase  out  PW  index of the active approach.
- start  out  1  one-cycle pulse in the first cycle of every green except the one loaded by reset.

## Operation
- All outputs are registered. State is one of GREEN, YELLOW or ALLRED. Registers are state, phase, cnt[CW-1:0] and pend.
- Reset:
  - Any edge with rst=1 loads GREEN, phase=0, cnt=0, pend=0.
  - Outputs after that edge: grn=1 (bit0), yel=0, phase=0, start=0.
  - rst overrides N and every transition, including mid-yellow and mid-all-red.
- GREEN, phase p:
  - cnt increments each edge.
  - When cnt==GREEN[p]-1, the next state is YELLOW with cnt=0.
  - grn[p]=1; all other grn and yel bits are 0.
- Early advance:
  - N=1 at an edge with cnt≥MIN_G-1 and cnt<GREEN[p]-1 moves to YELLOW at that edge.
  - N=1 with cnt<MIN_G-1 sets pend=1.
  - When pend=1 and cnt==MIN_G-1, the next state is YELLOW.
  - pend clears on leaving GREEN.
  - N is ignored in YELLOW and ALLRED, and is never latched there.
- YELLOW, phase p:
  - Lasts YELLOW cycles with yel[p]=1 and grn=0.
  - Then goes to ALLRED with cnt=0.
  - If ALLRED==0, it goes straight to GREEN of the next phase.
- ALLRED:
  - Lasts ALLRED cycles with grn=0 and yel=0; phase still shows p.
  - Then goes to GREEN with phase=(p+1) mod PHASES, cnt=0 and start=1 for one cycle.
- phase wraps from PHASES-1 to 0. It never takes a value ≥PHASES.
- Invariant: at most one bit set across grn|yel at any time.
- cnt never exceeds max(GREEN[p], YELLOW, ALLRED)-1, so there is no overflow.

## Timing
- Durations count edges. A green of G cycles means grn[p] is high for exactly G consecutive clk periods, including the entry cycle.
- After reset is released, grn[0] is high during the release cycle and drops at the edge that completes GREEN[0] cycles from the reset-load edge.
- Latency from N to the yel rise:
  - 1 edge when the minimum is met.
  - Otherwise the yellow starts at the edge where cnt==MIN_G-1.
- Default full rotation is 39 cycles:
  - Phase0: 10 green + 3 yellow + 1 all-red.
  - Phase1: 4 + 3 + 1.
  - Phase2: 13 + 3 + 1.
- start is coincident with the first cycle of grn[p'] for the new phase p'.

## Test plan
- Free run with defaults after a 2-cycle reset, N=0:
  - grn[0] high 10 cycles, yel[0] 3, all-dark 1.
  - grn[1] 4, yel[1] 3, all-dark 1, grn[2] 13.
  - Pattern repeats every 39 cycles; start pulses 3 times per rotation.
- Early advance: N pulsed 1 cycle at cnt=5 of phase0 → yel[0] rises at the next edge; grn[0] was high 6 cycles.
- Pending request: N pulsed at cnt=0 of phase1 (MIN_G=2) → grn[1] high exactly 2 cycles, then yel[1] for 3.
- Ignored request: N held high through yellow and all-red of phase0 → yellow is 3 cycles, all-red 1, then grn[1] high 2 cycles (MIN_G, since N is still high at the MIN_G-1 point).
- Reset mid-operation: rst asserted in yellow cycle 2 of phase2 → next edge gives grn=001, yel=000, phase=0, start=0; a normal 10-cycle green follows.
- Parameter sweep: PHASES=4, GREEN={5,5,5,5}, ALLRED=0 → period 32; phase sequence 0,1,2,3,0; yel→grn with no gap; one-hot invariant checked every cycle.
